// File: rtl/decode_67b_64b_if.sv
// Word-level bus between the RX gearbox side and the 64B/67B decoder.
// The decoder uses the slave modport. The gearbox or a bench uses the master modport.
interface decode_67b_64b_if;
    logic [66:0] DATA_IN;
    logic        DATA_IN_VALID;
    logic        PASSTHROUGH;
    logic [63:0] DATA_OUT;
    logic [1:0]  HEADER_OUT;
    logic        DATA_OUT_VALID;
    logic        BLOCK_LOCK;
    logic        SLIP;
    logic        HEADER_ERR;

    modport master (
        output DATA_IN, DATA_IN_VALID, PASSTHROUGH,
        input  DATA_OUT, HEADER_OUT, DATA_OUT_VALID, BLOCK_LOCK, SLIP, HEADER_ERR
    );

    modport slave (
        input  DATA_IN, DATA_IN_VALID, PASSTHROUGH,
        output DATA_OUT, HEADER_OUT, DATA_OUT_VALID, BLOCK_LOCK, SLIP, HEADER_ERR
    );
endinterface

// File: rtl/decode_67b_64b.sv
// 64B/67B receive decoder: strips the inversion bit, restores payload and sync header,
// and runs the block-lock FSM (hunt, slip hold-off, locked with error-window monitoring).
module decode_67b_64b #(
    parameter int LOCK_COUNT = 64,
    parameter int ERR_WINDOW = 64,
    parameter int ERR_LIMIT  = 16,
    parameter int SLIP_WAIT  = 32
) (
    input  logic                 USER_CLK,
    input  logic                 SYSTEM_RESET,
    decode_67b_64b_if.slave      bus
);
    localparam int SH_W = $clog2(LOCK_COUNT + 1);
    localparam int WT_W = $clog2(SLIP_WAIT + 1);
    localparam int WN_W = $clog2(ERR_WINDOW + 1);
    localparam int ER_W = $clog2(ERR_LIMIT + 1);

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        SLIP_HOLD = 2'd1,
        LOCKED    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [SH_W-1:0]  sh_cnt_q, sh_cnt_d;
    logic [WT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [WN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [ER_W-1:0]  err_cnt_q, err_cnt_d;
    logic [63:0]      data_out_q, data_out_d;
    logic [1:0]       header_out_q, header_out_d;
    logic             data_out_valid_q, data_out_valid_d;
    logic             block_lock_q, block_lock_d;
    logic             slip_q, slip_d;
    logic             header_err_q, header_err_d;

    logic             hdr_ok_s;
    logic [SH_W-1:0]  sh_inc_s;
    logic [WT_W-1:0]  wait_inc_s;
    logic [WN_W-1:0]  win_inc_s;
    logic [ER_W-1:0]  err_inc_s;

    assign hdr_ok_s   = (bus.DATA_IN[65:64] == 2'b01) || (bus.DATA_IN[65:64] == 2'b10);
    assign sh_inc_s   = sh_cnt_q + SH_W'(1);
    assign wait_inc_s = wait_cnt_q + WT_W'(1);
    assign win_inc_s  = win_cnt_q + WN_W'(1);
    assign err_inc_s  = hdr_ok_s ? err_cnt_q : err_cnt_q + ER_W'(1);

    // Next-state, counter and output computation for decode and block lock.
    always_comb begin
        state_d          = state_q;
        sh_cnt_d         = sh_cnt_q;
        wait_cnt_d       = wait_cnt_q;
        win_cnt_d        = win_cnt_q;
        err_cnt_d        = err_cnt_q;
        data_out_d       = data_out_q;
        header_out_d     = header_out_q;
        data_out_valid_d = 1'b0;
        slip_d           = 1'b0;
        header_err_d     = 1'b0;

        if (bus.PASSTHROUGH) begin
            state_d          = HUNT;
            sh_cnt_d         = '0;
            wait_cnt_d       = '0;
            win_cnt_d        = '0;
            err_cnt_d        = '0;
            data_out_valid_d = bus.DATA_IN_VALID;
            if (bus.DATA_IN_VALID) begin
                data_out_d   = bus.DATA_IN[63:0];
                header_out_d = bus.DATA_IN[65:64];
            end else begin
                data_out_d   = data_out_q;
            end
        end else begin
            if (bus.DATA_IN_VALID) begin
                data_out_d       = bus.DATA_IN[66] ? ~bus.DATA_IN[63:0] : bus.DATA_IN[63:0];
                header_out_d     = bus.DATA_IN[65:64];
                header_err_d     = ~hdr_ok_s;
                data_out_valid_d = (state_q == LOCKED);
            end else begin
                data_out_d       = data_out_q;
            end

            case (state_q)
                HUNT: begin
                    if (bus.DATA_IN_VALID && hdr_ok_s) begin
                        if (sh_inc_s == SH_W'(LOCK_COUNT)) begin
                            state_d  = LOCKED;
                            sh_cnt_d = '0;
                        end else begin
                            sh_cnt_d = sh_inc_s;
                        end
                    end else if (bus.DATA_IN_VALID) begin
                        slip_d     = 1'b1;
                        sh_cnt_d   = '0;
                        wait_cnt_d = '0;
                        state_d    = SLIP_HOLD;
                    end else begin
                        sh_cnt_d   = sh_cnt_q;
                    end
                end
                // Hold-off counts every clock, valid or not, so the gearbox can settle.
                SLIP_HOLD: begin
                    if (wait_inc_s == WT_W'(SLIP_WAIT)) begin
                        wait_cnt_d = '0;
                        state_d    = HUNT;
                    end else begin
                        wait_cnt_d = wait_inc_s;
                    end
                end
                LOCKED: begin
                    if (bus.DATA_IN_VALID) begin
                        if (err_inc_s == ER_W'(ERR_LIMIT)) begin
                            state_d   = HUNT;
                            sh_cnt_d  = '0;
                            win_cnt_d = '0;
                            err_cnt_d = '0;
                        end else if (win_inc_s == WN_W'(ERR_WINDOW)) begin
                            win_cnt_d = '0;
                            err_cnt_d = '0;
                        end else begin
                            win_cnt_d = win_inc_s;
                            err_cnt_d = err_inc_s;
                        end
                    end else begin
                        win_cnt_d = win_cnt_q;
                    end
                end
                default: begin
                    state_d    = HUNT;
                    sh_cnt_d   = '0;
                    wait_cnt_d = '0;
                    win_cnt_d  = '0;
                    err_cnt_d  = '0;
                end
            endcase
        end

        block_lock_d = (state_d == LOCKED);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge USER_CLK) begin
        if (SYSTEM_RESET) begin
            state_q          <= HUNT;
            sh_cnt_q         <= '0;
            wait_cnt_q       <= '0;
            win_cnt_q        <= '0;
            err_cnt_q        <= '0;
            data_out_q       <= 64'h0;
            header_out_q     <= 2'b00;
            data_out_valid_q <= 1'b0;
            block_lock_q     <= 1'b0;
            slip_q           <= 1'b0;
            header_err_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            sh_cnt_q         <= sh_cnt_d;
            wait_cnt_q       <= wait_cnt_d;
            win_cnt_q        <= win_cnt_d;
            err_cnt_q        <= err_cnt_d;
            data_out_q       <= data_out_d;
            header_out_q     <= header_out_d;
            data_out_valid_q <= data_out_valid_d;
            block_lock_q     <= block_lock_d;
            slip_q           <= slip_d;
            header_err_q     <= header_err_d;
        end
    end

    assign bus.DATA_OUT       = data_out_q;
    assign bus.HEADER_OUT     = header_out_q;
    assign bus.DATA_OUT_VALID = data_out_valid_q;
    assign bus.BLOCK_LOCK     = block_lock_q;
    assign bus.SLIP           = slip_q;
    assign bus.HEADER_ERR     = header_err_q;
endmodule
